// File: rtl/edge_pkg.sv
// Shared constants and helpers for the multi-channel edge detector.
// Optional event counters are enabled with macro EDGE_EVT_CNT_EN.
package edge_pkg;

  localparam int unsigned CH_DEF          = 4;
  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned DB_CYCLES_DEF   = 4;
  localparam int unsigned CNT_W_DEF       = 8;

  // Debounce counter width: clog2(db), never less than one bit.
  function automatic int unsigned db_cnt_w(input int unsigned db);
    return (db <= 2) ? 1 : $clog2(db);
  endfunction

endpackage

// File: rtl/edge_chan.sv
// One channel: synchroniser, debounce filter, edge pulses and an optional
// saturating rise counter (built only when EDGE_EVT_CNT_EN is defined).
module edge_chan
  import edge_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned DB_CYCLES   = DB_CYCLES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_a,
  input  logic             en,
  input  logic             clr_cnt,
  output logic             level,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] evt_cnt
);

  localparam int unsigned DBW = db_cnt_w(DB_CYCLES);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [DBW-1:0]         cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  assign sync = sync_q[SYNC_STAGES-1];

  // Synchroniser shift chain; runs independently of en.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], in_a};
  end

  // Debounce: level follows sync only after DB_CYCLES consecutive differing edges.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (en) begin
      if (sync == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == DB_LAST) begin
        level_d = sync;
        cnt_d   = '0;
        rise_d  = sync;
        fall_d  = ~sync;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debounce state and registered pulse outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

`ifdef EDGE_EVT_CNT_EN
  logic [CNT_W-1:0] evt_q, evt_d;

  // Saturating rise counter; counts on the edge the rise pulse is produced,
  // so a coincident clear discards that event.
  always_comb begin
    evt_d = evt_q;
    if (clr_cnt)
      evt_d = '0;
    else if (rise_d && !(&evt_q))
      evt_d = evt_q + 1'b1;
  end

  // Event counter register.
  always_ff @(posedge clk) begin
    if (rst) evt_q <= '0;
    else     evt_q <= evt_d;
  end

  assign evt_cnt = evt_q;
`else
  logic unused_clr_cnt;
  assign unused_clr_cnt = clr_cnt;
  assign evt_cnt = '0;
`endif

endmodule

// File: rtl/edge_detect_multi.sv
// Multi-channel debounced edge detector: CH independent edge_chan instances.
// Optional per-channel rise counters are enabled with macro EDGE_EVT_CNT_EN.
module edge_detect_multi
  import edge_pkg::*;
#(
  parameter int unsigned CH          = CH_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned DB_CYCLES   = DB_CYCLES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH-1:0]       in_a,
  input  logic                en,
  input  logic                clr_cnt,
  output logic [CH-1:0]       level,
  output logic [CH-1:0]       rise,
  output logic [CH-1:0]       fall,
  output logic [CH*CNT_W-1:0] evt_cnt
);

  for (genvar i = 0; i < CH; i++) begin : g_chan
    edge_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .DB_CYCLES  (DB_CYCLES),
      .CNT_W      (CNT_W)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .in_a   (in_a[i]),
      .en     (en),
      .clr_cnt(clr_cnt),
      .level  (level[i]),
      .rise   (rise[i]),
      .fall   (fall[i]),
      .evt_cnt(evt_cnt[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_edge_detect_multi.sv
// Directed bench for edge_detect_multi (CH=4, SYNC_STAGES=2, DB_CYCLES=4, CNT_W=8).
module tb_edge_detect_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_a;
  logic        en;
  logic        clr_cnt;
  logic [3:0]  level, rise, fall;
  logic [31:0] evt_cnt;

  int checks   = 0;
  int failures = 0;

  edge_detect_multi #(
    .CH(4), .SYNC_STAGES(2), .DB_CYCLES(4), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .in_a(in_a), .en(en), .clr_cnt(clr_cnt),
    .level(level), .rise(rise), .fall(fall), .evt_cnt(evt_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; in_a = '0; en = 1'b1; clr_cnt = 1'b0;
    tick(); tick();
    chk("rst_level", {28'd0, level}, 32'd0);
    chk("rst_rise",  {28'd0, rise},  32'd0);
    chk("rst_fall",  {28'd0, fall},  32'd0);
    chk("rst_evt",   evt_cnt,        32'd0);
    rst = 1'b0;
    tick();

    // Channel 0 rises: level and rise on edge 6.
    in_a[0] = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      chk($sformatf("c0_level_e%0d", e), {28'd0, level}, (e >= 6) ? 32'h1 : 32'h0);
      chk($sformatf("c0_rise_e%0d", e),  {28'd0, rise},  (e == 6) ? 32'h1 : 32'h0);
      chk($sformatf("c0_fall_e%0d", e),  {28'd0, fall},  32'h0);
    end

    // Channel 1 glitch of 3 cycles: filtered out.
    in_a[1] = 1'b1;
    tick(); tick(); tick();
    in_a[1] = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk($sformatf("glitch_level_e%0d", e), {28'd0, level}, 32'h1);
      chk($sformatf("glitch_rise_e%0d", e),  {28'd0, rise},  32'h0);
      chk($sformatf("glitch_fall_e%0d", e),  {28'd0, fall},  32'h0);
    end

    // Channel 2 stable high, then driven low: fall on edge 6.
    in_a[2] = 1'b1;
    repeat (8) tick();
    chk("c2_high_level", {28'd0, level}, 32'h5);
    in_a[2] = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      chk($sformatf("c2_fall_e%0d", e),  {28'd0, fall},  (e == 6) ? 32'h4 : 32'h0);
      chk($sformatf("c2_level_e%0d", e), {28'd0, level}, (e >= 6) ? 32'h1 : 32'h5);
      chk($sformatf("c2_rise_e%0d", e),  {28'd0, rise},  32'h0);
    end

    // Reset mid-debounce on channel 0 (cnt reaches 2 after 4 edges).
    in_a[0] = 1'b0;
    repeat (8) tick();
    chk("c0_low_level", {28'd0, level}, 32'h0);
    in_a[0] = 1'b1;
    repeat (4) tick();
    chk("c0_mid_level", {28'd0, level}, 32'h0);
    rst = 1'b1;
    tick();
    chk("mid_rst_level", {28'd0, level}, 32'h0);
    chk("mid_rst_rise",  {28'd0, rise},  32'h0);
    chk("mid_rst_fall",  {28'd0, fall},  32'h0);
    chk("mid_rst_evt",   evt_cnt,        32'h0);
    rst = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      chk($sformatf("post_rst_rise_e%0d", e), {28'd0, rise},  (e == 6) ? 32'h1 : 32'h0);
      chk($sformatf("post_rst_lvl_e%0d", e),  {28'd0, level}, (e >= 6) ? 32'h1 : 32'h0);
    end

    // en=0 freezes channel 1; re-enable gives rise on 4th edge.
    en = 1'b0;
    in_a[1] = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      chk($sformatf("dis_level_e%0d", e), {28'd0, level}, 32'h1);
      chk($sformatf("dis_rise_e%0d", e),  {28'd0, rise},  32'h0);
      chk($sformatf("dis_fall_e%0d", e),  {28'd0, fall},  32'h0);
    end
    en = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      chk($sformatf("reen_rise_e%0d", e),  {28'd0, rise},  (e == 4) ? 32'h2 : 32'h0);
      chk($sformatf("reen_level_e%0d", e), {28'd0, level}, (e >= 4) ? 32'h3 : 32'h1);
    end

`ifdef EDGE_EVT_CNT_EN
    chk("evt_after_reen", evt_cnt, 32'h0000_0101);
    for (int n = 0; n < 300; n++) begin
      in_a[3] = 1'b1;
      repeat (7) tick();
      in_a[3] = 1'b0;
      repeat (7) tick();
    end
    chk("evt_sat", evt_cnt, 32'hFF00_0101);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("evt_clr", evt_cnt, 32'h0);
    in_a[3] = 1'b1;
    repeat (5) tick();
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("clr_coinc_rise", {28'd0, rise}, 32'h8);
    chk("clr_coinc_evt",  evt_cnt,       32'h0);
    tick();
    chk("clr_coinc_evt_after", evt_cnt, 32'h0);
`else
    clr_cnt = 1'b1;
    in_a[3] = 1'b1;
    repeat (6) tick();
    clr_cnt = 1'b0;
    chk("nocnt_rise3_level", {28'd0, level}, 32'hB);
    chk("nocnt_evt", evt_cnt, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/edge_detect_multi.md
EDGE_DETECT_MULTI -- requirements
Module: edge_detect_multi

Interface
REQ-001 Parameter CH, default 4: number of independent input channels, at least 1.
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser flop depth per channel, at least 2.
REQ-003 Parameter DB_CYCLES, default 4: debounce hold time in clk cycles, at least 1.
REQ-004 Parameter CNT_W, default 8: per-channel event counter width, at least 1.
REQ-005 The block SHALL use one clock and a synchronous, active-high reset: clk for the clock, rst for the reset.
REQ-006 Port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-007 Port rst, input, 1 bit: synchronous active-high reset.
REQ-008 Port in_a, input, CH bits: asynchronous raw level inputs, one bit per channel.
REQ-009 Port en, input, 1 bit: global debounce/detect enable.
REQ-010 Port clr_cnt, input, 1 bit: synchronous clear of all event counters.
REQ-011 Port level, output, CH bits: debounced stable level per channel, registered.
REQ-012 Port rise, output, CH bits: one-cycle pulse when level changes 0->1, registered.
REQ-013 Port fall, output, CH bits: one-cycle pulse when level changes 1->0, registered.
REQ-014 Port evt_cnt, output, CH*CNT_W bits: per-channel rising-event counts; channel i occupies bits [i*CNT_W +: CNT_W].

Function
REQ-015 Each channel SHALL pass in_a[i] through SYNC_STAGES flops; the last flop output is sync[i].
- The synchroniser runs regardless of en.
REQ-016 Each channel SHALL hold a debounce counter cnt of width clog2(DB_CYCLES) (minimum 1 bit).
REQ-017 Debounce update rule, applied on each edge with en=1:
- If sync[i] equals level[i]: cnt <= 0.
- Otherwise, if cnt == DB_CYCLES-1: level[i] <= sync[i] and cnt <= 0.
- Otherwise: cnt <= cnt+1.
REQ-018 Latency: with edge 1 being the first edge that samples a new in_a value held steady, level SHALL change on edge SYNC_STAGES+DB_CYCLES.
- Defaults give edge 6.
REQ-019 Glitch filtering: a sync value differing from level for fewer than DB_CYCLES consecutive edges SHALL NOT change level, rise or fall.
REQ-020 rise[i] and fall[i] SHALL assert on the same edge that level[i] toggles, for exactly one cycle.
- rise and fall for one channel are never asserted together.
REQ-021 With en=0, cnt and level SHALL hold their values, and rise and fall SHALL be 0.
- Counting resumes from the held cnt when en returns to 1.
REQ-022 Channels SHALL be fully independent: simultaneous events on several channels each produce their own pulses in the same cycle.

Reset
REQ-023 With rst=1 at a clk edge, the following SHALL be cleared to 0: all synchroniser flops, cnt, level, rise, fall and evt_cnt.
- rst has priority over en and clr_cnt.
REQ-024 Reset during a debounce in progress SHALL discard the partial count.
- If in_a is held 1 through the reset, rise asserts on edge SYNC_STAGES+DB_CYCLES after rst deasserts.

Configuration
REQ-025 With macro EDGE_EVT_CNT_EN defined, each channel SHALL count its rise pulses in a CNT_W-bit counter.
- The counter saturates at all-ones; it does not wrap.
REQ-026 With EDGE_EVT_CNT_EN defined, clr_cnt=1 SHALL zero all counters on that edge.
- Clear wins over a coincident rise; that event is not counted.
REQ-027 Without EDGE_EVT_CNT_EN, evt_cnt SHALL be constant 0, no counter flops are built, and clr_cnt is ignored.

Structure
REQ-028 Package edge_pkg SHALL hold the default parameter constants and the debounce counter width function.
REQ-029 Sub-module edge_chan SHALL implement one channel:
- synchroniser, debounce, pulse generation, and the optional counter.
- edge_detect_multi instantiates it CH times in a generate loop.

Verification (CH=4, SYNC_STAGES=2, DB_CYCLES=4, CNT_W=8)
REQ-030 Reset, then in_a[0] 0->1 held: level[0]=1 and rise[0]=1 for one cycle at edge 6; channels 1-3 stay quiet.
REQ-031 in_a[1]=1 for 3 cycles, then 0: level[1], rise[1] and fall[1] stay 0 throughout.
REQ-032 in_a[2] stable at 1, then driven to 0: fall[2] pulses once at edge 6 and level[2]=0.
REQ-033 Macro defined, 300 debounced rises on channel 3: evt_cnt[3]=255 (saturated).
- clr_cnt=1 then gives 0.
- clr_cnt coincident with a rise also gives 0.
REQ-034 rst asserted with cnt=2 while in_a[0] is held 1: all outputs 0; after deassert, rise[0] at edge 6.
REQ-035 en=0 while in_a[1] toggles to 1: level holds 0 and no pulses occur; en=1 gives rise[1] at edge 4 after the re-enable edge.
- The synchroniser was already settled, so only DB_CYCLES edges remain.
